// File: rtl/decode_pkg.sv
// Shared instruction field layout, NOP encoding and issue-control state enum
// for the decode/issue slice.
package decode_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int IMM_LSB = 0;

  localparam logic [FIELD_W-1:0] OPC_NOP = 4'h0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } issue_state_e;

endpackage

// File: rtl/issue_fifo.sv
// Instruction buffer: head visible combinationally, write to read in one cycle.
// Push while full is taken only together with a pop; flush overrides push and pop.
module issue_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign head_data = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Scoreboarded in-order issue from a small buffer; issue is combinational off the head.
// Hazards hold the head (stall); flush drains outstanding writebacks before refill. ISSUE_PERF_CNT_EN adds stall_cycles.
module decode_issue_ctrl
  import decode_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int REG_COUNT  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_valid,
  input  logic [15:0]          f_instr,
  output logic                 f_ready,
  output logic                 d_valid,
  output logic [15:0]          d_instr,
  input  logic                 d_ready,
  input  logic                 wb_valid,
  input  logic [3:0]           wb_rd,
  input  logic                 flush,
  output logic                 stall,
  output logic [REG_COUNT-1:0] busy_regs
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  issue_state_e           state_q, state_d;
  logic [REG_COUNT-1:0]   busy_q, busy_d, wb_clr, busy_eff;
  logic [INSTR_W-1:0]     head;
  logic [FIELD_W-1:0]     head_opc, head_rd, head_rs;
  logic                   full, empty, run, hazard;
  logic                   do_push, do_pop, fifo_flush;

  function automatic logic busy_at(input logic [REG_COUNT-1:0] v, input logic [3:0] r);
    busy_at = (int'(r) < REG_COUNT) ? v[r] : 1'b0;
  endfunction

  issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_push),
    .push_data (f_instr),
    .pop       (do_pop),
    .flush     (fifo_flush),
    .head_data (head),
    .full      (full),
    .empty     (empty)
  );

  assign head_opc = head[OPC_LSB +: FIELD_W];
  assign head_rd  = head[RD_LSB  +: FIELD_W];
  assign head_rs  = head[RS_LSB  +: FIELD_W];

  always_comb begin
    wb_clr = '0;
    if (wb_valid && (int'(wb_rd) < REG_COUNT)) wb_clr[wb_rd] = 1'b1;
  end

  // A writeback landing this cycle already unblocks the head this cycle.
  assign busy_eff = busy_q & ~wb_clr;
  assign hazard   = (head_opc != OPC_NOP) &&
                    (busy_at(busy_eff, head_rs) || busy_at(busy_eff, head_rd));

  // Outputs are qualified with rst_n so they read idle while reset is held.
  assign run     = rst_n && (state_q == ST_RUN);
  assign f_ready = run && !full;
  assign d_valid = run && !empty && !hazard;
  assign stall   = run && !empty && hazard;
  assign d_instr = rst_n ? head : '0;

  assign fifo_flush = run && flush;
  assign do_push    = f_valid && f_ready && !flush;
  assign do_pop     = d_valid && d_ready && !flush;

  assign busy_regs = busy_q;

  always_comb begin
    busy_d = busy_q & ~wb_clr;
    // Issue set is applied after the writeback clear so it wins on a collision.
    if (do_pop && (head_opc != OPC_NOP) && (int'(head_rd) < REG_COUNT)) begin
      busy_d[head_rd] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (busy_q == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl at FIFO_DEPTH=2, REG_COUNT=16.
// Stall-counter checks are compiled in when ISSUE_PERF_CNT_EN is defined.
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic [15:0] f_instr;
  logic        f_ready;
  logic        d_valid;
  logic [15:0] d_instr;
  logic        d_ready;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        flush;
  logic        stall;
  logic [15:0] busy_regs;
`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  decode_issue_ctrl #(
    .FIFO_DEPTH (2),
    .REG_COUNT  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_valid   (f_valid),
    .f_instr   (f_instr),
    .f_ready   (f_ready),
    .d_valid   (d_valid),
    .d_instr   (d_instr),
    .d_ready   (d_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .stall     (stall),
    .busy_regs (busy_regs)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0; f_valid = 1'b0; f_instr = '0; d_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_f_ready", 32'(f_ready), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_instr", 32'(d_instr), 32'h0);
    chk("rst_stall",   32'(stall),   32'd0);
    chk("rst_busy",    32'(busy_regs), 32'h0);
    rst_n = 1'b1; #1;
    chk("post_rst_f_ready", 32'(f_ready), 32'd1);
    chk("post_rst_d_valid", 32'(d_valid), 32'd0);

    // RAW hazard on rs=2, released by same-cycle writeback
    f_valid = 1'b1; f_instr = 16'h1230; d_ready = 1'b1;
    cyc();
    f_instr = 16'h2420; #1;
    chk("raw_d_valid1", 32'(d_valid), 32'd1);
    chk("raw_d_instr1", 32'(d_instr), 32'h1230);
    cyc();
    f_valid = 1'b0; #1;
    chk("raw_busy2",    32'(busy_regs), 32'h0004);
    chk("raw_d_instr2", 32'(d_instr), 32'h2420);
    chk("raw_stall_a",  32'(stall), 32'd1);
    chk("raw_d_valid_a", 32'(d_valid), 32'd0);
    cyc();
    chk("raw_stall_b",  32'(stall), 32'd1);
    wb_valid = 1'b1; wb_rd = 4'd2; #1;
    chk("raw_wb_d_valid", 32'(d_valid), 32'd1);
    chk("raw_wb_stall",   32'(stall), 32'd0);
    cyc();
    wb_valid = 1'b0; #1;
    chk("raw_busy4",  32'(busy_regs), 32'h0010);
    chk("raw_empty",  32'(d_valid), 32'd0);

    // Same-cycle issue of rd=5 and writeback of r5: set wins
    f_valid = 1'b1; f_instr = 16'h3500; d_ready = 1'b0; wb_valid = 1'b1; wb_rd = 4'd4;
    cyc();
    f_valid = 1'b0; d_ready = 1'b1; wb_rd = 4'd5; #1;
    chk("col_d_valid", 32'(d_valid), 32'd1);
    cyc();
    wb_valid = 1'b0; #1;
    chk("col_busy", 32'(busy_regs), 32'h0020);

    // NOP touching busy r5 issues freely and sets nothing
    f_valid = 1'b1; f_instr = 16'h0550; d_ready = 1'b0;
    cyc();
    f_valid = 1'b0; d_ready = 1'b1; #1;
    chk("nop_d_valid", 32'(d_valid), 32'd1);
    chk("nop_stall",   32'(stall), 32'd0);
    cyc();
    chk("nop_busy",    32'(busy_regs), 32'h0020);
    chk("nop_empty",   32'(d_valid), 32'd0);

    // Fill to depth 2 with decode blocked; third push waits for the first pop
    d_ready = 1'b0; f_valid = 1'b1; f_instr = 16'h1670; #1;
    chk("fill_rdy0", 32'(f_ready), 32'd1);
    cyc();
    f_instr = 16'h1780; #1;
    chk("fill_rdy1", 32'(f_ready), 32'd1);
    cyc();
    f_instr = 16'h1890; #1;
    chk("fill_full_a", 32'(f_ready), 32'd0);
    cyc();
    chk("fill_full_b", 32'(f_ready), 32'd0);
    d_ready = 1'b1; #1;
    chk("fill_rdy_indep", 32'(f_ready), 32'd0);
    chk("fill_head", 32'(d_instr), 32'h1670);
    cyc();
    d_ready = 1'b0; #1;
    chk("fill_rdy_after_pop", 32'(f_ready), 32'd1);
    chk("fill_busy", 32'(busy_regs), 32'h0060);
    cyc();
    f_valid = 1'b0; #1;
    chk("fill_head2", 32'(d_instr), 32'h1780);
    chk("fill_full_c", 32'(f_ready), 32'd0);

    // Reset mid-operation discards buffer and scoreboard
    rst_n = 1'b0; #1;
    chk("mrst_f_ready", 32'(f_ready), 32'd0);
    chk("mrst_d_valid", 32'(d_valid), 32'd0);
    chk("mrst_d_instr", 32'(d_instr), 32'h0);
    cyc();
    chk("mrst_busy", 32'(busy_regs), 32'h0);
    rst_n = 1'b1; #1;
    chk("mrst_rel_f_ready", 32'(f_ready), 32'd1);
    chk("mrst_rel_d_valid", 32'(d_valid), 32'd0);

    // Flush with r1,r2 outstanding: DRAIN until both write back
    f_valid = 1'b1; f_instr = 16'h1100; d_ready = 1'b1;
    cyc();
    f_instr = 16'h1200;
    cyc();
    f_instr = 16'h1300;
    cyc();
    f_valid = 1'b0; d_ready = 1'b0; #1;
    chk("fl_busy_pre",  32'(busy_regs), 32'h0006);
    chk("fl_d_valid_pre", 32'(d_valid), 32'd1);
    flush = 1'b1; f_valid = 1'b1; f_instr = 16'h1400; d_ready = 1'b1;
    cyc();
    flush = 1'b0; f_valid = 1'b0; #1;
    chk("fl_busy_kept", 32'(busy_regs), 32'h0006);
    chk("fl_f_ready",   32'(f_ready), 32'd0);
    chk("fl_d_valid",   32'(d_valid), 32'd0);
    wb_valid = 1'b1; wb_rd = 4'd1;
    cyc();
    chk("fl_busy_r2", 32'(busy_regs), 32'h0004);
    chk("fl_drain_a", 32'(f_ready), 32'd0);
    wb_rd = 4'd2;
    cyc();
    wb_valid = 1'b0; #1;
    chk("fl_busy_zero", 32'(busy_regs), 32'h0);
    chk("fl_drain_b",   32'(f_ready), 32'd0);
    cyc();
    chk("fl_run_f_ready", 32'(f_ready), 32'd1);
    chk("fl_run_empty",   32'(d_valid), 32'd0);

    // Ten stall cycles, then reset while stalled
    f_valid = 1'b1; f_instr = 16'h1500; d_ready = 1'b1;
    cyc();
    f_instr = 16'h1050;
    cyc();
    f_valid = 1'b0; #1;
    chk("pc_stall_start", 32'(stall), 32'd1);
`ifdef ISSUE_PERF_CNT_EN
    chk("pc_cnt_zero", 32'(stall_cycles), 32'd0);
`endif
    repeat (10) cyc();
    chk("pc_stall_end", 32'(stall), 32'd1);
`ifdef ISSUE_PERF_CNT_EN
    chk("pc_cnt_ten", 32'(stall_cycles), 32'd10);
`endif
    rst_n = 1'b0; #1;
    chk("pc_rst_stall",   32'(stall), 32'd0);
    chk("pc_rst_d_valid", 32'(d_valid), 32'd0);
    chk("pc_rst_f_ready", 32'(f_ready), 32'd0);
    cyc();
    chk("pc_rst_busy",    32'(busy_regs), 32'h0);
    chk("pc_rst_d_instr", 32'(d_instr), 32'h0);
`ifdef ISSUE_PERF_CNT_EN
    chk("pc_rst_cnt", 32'(stall_cycles), 32'd0);
`endif
    rst_n = 1'b1; #1;
    chk("pc_rel_f_ready", 32'(f_ready), 32'd1);
    chk("pc_rel_stall",   32'(stall), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
